// File: rtl/config_stream_pkg.sv
// Shared types and default marker words for the configuration-stream deserialiser.
package config_stream_pkg;

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    localparam logic [15:0] DEF_SYNC_WORD = 16'hFAB2;
    localparam logic [15:0] DEF_END_WORD  = 16'hFAB3;

endpackage

// File: rtl/config_timeout_cnt.sv
// Idle-timeout down-counter: loads TIMEOUT, decrements while enabled, flags the cycle it reaches zero.
module config_timeout_cnt #(
    parameter int TIMEOUT = 49
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_dec,
    output logic o_expire
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= CW'(TIMEOUT);
        end else if (i_load) begin
            r_count <= CW'(TIMEOUT);
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CW'(1);
        end
    end

    // Expire on the decrement that lands on zero, so the owner leaves HUNT on that same edge.
    assign o_expire = i_dec && (r_count <= CW'(1));

endmodule

// File: rtl/config_stream_deser.sv
// Serial config-stream deserialiser: hunts for SYNC_WORD, collects DATA_W payload bits, stops on END_WORD or idle timeout.
// Define CONFIG_PARITY_EN to expect one odd-parity bit after every payload.
module config_stream_deser
    import config_stream_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                SYNC_W    = 16,
    parameter logic [SYNC_W-1:0] SYNC_WORD = DEF_SYNC_WORD,
    parameter logic [SYNC_W-1:0] END_WORD  = DEF_END_WORD,
    parameter int                TIMEOUT   = 49,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_in,
    input  logic              data_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              strobe,
    output logic              finished,
    output logic [CNT_W-1:0]  frame_count,
    output logic              error
);
`ifdef CONFIG_PARITY_EN
    localparam int FRAME_BITS = DATA_W + 1;
`else
    localparam int FRAME_BITS = DATA_W;
`endif
    localparam int HIST_W    = FRAME_BITS - 1;
    localparam int BIT_CNT_W = $clog2(FRAME_BITS);

    state_e               r_state;
    state_e               w_state_next;
    logic [SYNC_W-2:0]    r_window;
    logic [SYNC_W-1:0]    w_window_next;
    logic [HIST_W-1:0]    r_payload;
    logic [DATA_W-1:0]    w_payload_final;
    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic [DATA_W-1:0]    r_data_out;
    logic                 r_strobe;
    logic [CNT_W-1:0]     r_frame_count;
    logic                 w_sync_hit;
    logic                 w_end_hit;
    logic                 w_last_bit;
    logic                 w_par_ok;
    logic                 w_frame_ok;
    logic                 w_expire;

    // Only SYNC_W-1 history bits are stored; the incoming bit completes the window.
    assign w_window_next = {r_window, data_in};
    assign w_sync_hit    = (r_state == ST_HUNT) && data_valid && (w_window_next == SYNC_WORD);
    assign w_end_hit     = (r_state == ST_HUNT) && data_valid && (w_window_next == END_WORD);
    assign w_last_bit    = (r_state == ST_PAYLOAD) && data_valid
                           && (r_bit_cnt == BIT_CNT_W'(FRAME_BITS - 1));
    assign w_frame_ok    = w_last_bit && w_par_ok;

    config_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_frame_ok),
        .i_dec    (r_state == ST_HUNT),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
        if (reset) r_state <= ST_HUNT;
        else       r_state <= w_state_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns w_state_next and no latch is inferred.
        w_state_next = r_state;
        case (r_state)
            ST_HUNT: begin
                if (w_end_hit || w_expire) w_state_next = ST_DONE;
                else if (w_sync_hit)       w_state_next = ST_PAYLOAD;
            end
            ST_PAYLOAD: if (w_last_bit) w_state_next = ST_HUNT;
            ST_DONE:    w_state_next = ST_DONE;
            default:    w_state_next = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_window      <= '0;
            r_payload     <= '0;
            r_bit_cnt     <= '0;
            r_data_out    <= '0;
            r_strobe      <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_strobe <= w_frame_ok;
            if (w_frame_ok) begin
                r_data_out <= w_payload_final;
                if (r_frame_count != '1) r_frame_count <= r_frame_count + 1'b1;
            end
            // Window clears after a payload so no marker can straddle the frame boundary.
            if ((r_state == ST_HUNT) && data_valid) r_window <= w_window_next[SYNC_W-2:0];
            else if (w_last_bit)                    r_window <= '0;
            if (w_sync_hit) begin
                r_bit_cnt <= '0;
            end else if ((r_state == ST_PAYLOAD) && data_valid) begin
                r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
                if (!w_last_bit) r_payload <= {r_payload[HIST_W-2:0], data_in};
            end
        end
    end

`ifdef CONFIG_PARITY_EN
    logic r_parity;
    logic r_error;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_parity <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            if (w_sync_hit) r_parity <= 1'b0;
            else if ((r_state == ST_PAYLOAD) && data_valid && !w_last_bit)
                r_parity <= r_parity ^ data_in;
            if (w_last_bit && !w_par_ok) r_error <= 1'b1;
        end
    end

    // Odd parity: payload ones plus the parity bit must be odd.
    assign w_par_ok        = r_parity ^ data_in;
    assign w_payload_final = r_payload;
    assign error           = r_error;
`else
    assign w_par_ok        = 1'b1;
    assign w_payload_final = {r_payload, data_in};
    assign error           = 1'b0;
`endif

    assign data_out    = r_data_out;
    assign strobe      = r_strobe;
    assign finished    = (r_state == ST_DONE);
    assign frame_count = r_frame_count;

endmodule
